// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared constants and the fetch buffer entry type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] data;
        logic        filled;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Brief    : Ring of fetch entries; allocated at tail, filled in order, drained at head.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [63:0]              push_pc_i,
    input  logic                     fill_i,
    input  logic [31:0]              fill_data_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output fetch_entry_t             head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = PW + 1;

    fetch_entry_t  entries_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] fill_q;
    logic [PW-1:0] tail_q;
    logic [BW-1:0] count_q;

    // Push and fill never target the same slot: a push needs a free slot,
    // a fill always lands on an already allocated one.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].filled <= 1'b0;
            end
        end else begin
            if (push_i) begin
                entries_q[tail_q].pc     <= push_pc_i;
                entries_q[tail_q].filled <= 1'b0;
                tail_q                   <= tail_q + PW'(1);
            end
            if (fill_i) begin
                entries_q[fill_q].data   <= fill_data_i;
                entries_q[fill_q].filled <= 1'b1;
                fill_q                   <= fill_q + PW'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + BW'(push_i) - BW'(pop_i);
        end
    end

    assign count_o = count_q;
    assign head_o  = entries_q[head_q];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Fetch stage: owns the PC, issues imem requests, hands {instr, pc} to decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [63:0] RESET_PC = fetch_unit_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam int CW = $clog2(2 * DEPTH) + 1;
    localparam int BW = $clog2(DEPTH) + 1;

    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [BW-1:0] count;
    fetch_entry_t  head;
    logic          accept;
    logic          resp_keep;
    logic          resp_drop;
    logic          consume;

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (accept),
        .push_pc_i   (pc_q),
        .fill_i      (resp_keep),
        .fill_data_i (imem_resp_data),
        .pop_i       (consume),
        .count_o     (count),
        .head_o      (head)
    );

    always_comb begin
        imem_req_valid = !rst && !redirect_valid && (count < BW'(DEPTH));
        accept         = imem_req_valid && imem_req_ready;
        // Words owed to a flushed stream are consumed before any new word is kept.
        resp_drop      = imem_resp_valid && (drop_cnt_q != '0);
        resp_keep      = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
        instr_valid    = !rst && !redirect_valid && (count != '0) && head.filled;
        consume        = instr_valid && instr_ready;

        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = {redirect_pc[63:2], 2'b00};
            inflight_d = '0;
            drop_cnt_d = drop_cnt_q + inflight_q - CW'(imem_resp_valid);
        end else begin
            if (accept) begin
                pc_d = pc_q + 64'd4;
            end
            inflight_d = inflight_q + CW'(accept) - CW'(resp_keep);
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            assert (!(imem_resp_valid && (inflight_q == '0) && (drop_cnt_q == '0)));
            assert (({1'b0, inflight_q} + {1'b0, drop_cnt_q}) <= (CW + 1)'(2 * DEPTH));
        end
    end

    assign imem_req_addr = pc_q;
    assign instr         = head.data;
    assign instr_pc      = head.pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed bench for fetch_unit with an in-order imem model (data = ~addr).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;
    int          ncons   = 0;
    int          naccept = 0;
    int          rdy_mode = 1;   // 0 never, 1 always, 2 random
    int          fixed_lat = 1;
    bit          rand_lat = 1'b0;
    bit          hold_resp = 1'b0;
    logic [63:0] exp_pc = RPC;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // imem model: in-order responses, data is the bitwise inverse of the address
    always @(negedge clk) begin
        if (!hold_resp && pend.size() != 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~pend[0].addr[31:0];
            void'(pend.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        case (rdy_mode)
            0:       imem_req_ready = 1'b0;
            1:       imem_req_ready = 1'b1;
            default: imem_req_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{imem_req_addr,
                             cyc + (rand_lat ? int'($urandom_range(1, 4)) : fixed_lat)});
            naccept++;
        end
    end

    // Every instruction handed to decode must follow the expected sequential stream
    always @(negedge clk) begin
        #2;
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            chk("stream_pc", instr_pc, exp_pc);
            chk("stream_data", {32'h0, instr}, {32'h0, ~exp_pc[31:0]});
            exp_pc = exp_pc + 64'd4;
            ncons++;
        end
    end

    initial begin
        int n0;
        bit found;

        // Reset state
        step(3);
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'd0);
        chk("rst_instr_valid", {63'h0, instr_valid}, 64'd0);

        // Straight-line fetch, 1-cycle imem, decode always ready
        rst = 1'b0;
        #1;
        chk("first_req_valid", {63'h0, imem_req_valid}, 64'd1);
        chk("first_req_addr", imem_req_addr, RPC);
        step(1);
        chk("fill_lat_c1", {63'h0, instr_valid}, 64'd0);
        step(1);
        chk("fill_lat_c2", {63'h0, instr_valid}, 64'd1);
        chk("first_instr_pc", instr_pc, RPC);
        n0 = ncons;
        step(10);
        chk("throughput", 64'(ncons - n0), 64'd10);

        // Backpressure after a redirect: exactly DEPTH requests, then stall
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        instr_ready    = 1'b0;
        exp_pc         = 64'h2000;
        #1;
        chk("redir_forces_invalid", {63'h0, instr_valid}, 64'd0);
        chk("redir_no_req", {63'h0, imem_req_valid}, 64'd0);
        step(1);
        redirect_valid = 1'b0;
        n0 = naccept;
        step(10);
        chk("full_accepts", 64'(naccept - n0), 64'(DEPTH));
        chk("full_no_req", {63'h0, imem_req_valid}, 64'd0);
        chk("full_head_valid", {63'h0, instr_valid}, 64'd1);
        chk("full_head_pc", instr_pc, 64'h2000);
        instr_ready = 1'b1;
        #1;
        chk("full_same_cycle_no_req", {63'h0, imem_req_valid}, 64'd0);
        step(1);
        chk("full_resume_req", {63'h0, imem_req_valid}, 64'd1);
        step(8);

        // Redirect to 0x1002 with two requests in flight
        rdy_mode = 0;
        step(6);
        hold_resp = 1'b1;
        rdy_mode  = 1;
        n0 = naccept;
        step(2);
        rdy_mode = 0;
        chk("two_in_flight", 64'(naccept - n0), 64'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1002;
        exp_pc         = 64'h1000;
        step(1);
        redirect_valid = 1'b0;
        hold_resp      = 1'b0;
        rdy_mode       = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (instr_valid === 1'b1) found = 1'b1;
        end
        chk("redir_instr_seen", {63'h0, found}, 64'd1);
        chk("redir_instr_pc", instr_pc, 64'h1000);
        step(6);

        // Redirect colliding with a response and a ready consumer
        rdy_mode    = 0;
        instr_ready = 1'b1;
        step(8);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        instr_ready    = 1'b0;
        exp_pc         = 64'h4000;
        fixed_lat      = 2;
        step(1);
        redirect_valid = 1'b0;
        rdy_mode       = 1;
        step(3);
        rdy_mode = 0;
        chk("coll_head_valid", {63'h0, instr_valid}, 64'd1);
        chk("coll_head_pc", instr_pc, 64'h4000);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5000;
        instr_ready    = 1'b1;
        exp_pc         = 64'h5000;
        #1;
        chk("coll_no_consume", {63'h0, instr_valid}, 64'd0);
        step(1);
        redirect_valid = 1'b0;

        // Random imem acceptance and latency, random decode stalls
        rand_lat = 1'b1;
        rdy_mode = 2;
        n0 = ncons;
        for (int i = 0; i < 200; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        instr_ready = 1'b1;
        chk("ring_wraps", {63'h0, ((ncons - n0) >= 3 * DEPTH)}, 64'd1);

        // Reset mid-stream with one request in flight
        rdy_mode = 0;
        rand_lat = 1'b0;
        step(12);
        fixed_lat = 3;
        rdy_mode  = 1;
        n0 = naccept;
        step(1);
        rdy_mode = 0;
        chk("one_in_flight", 64'(naccept - n0), 64'd1);
        step(1);
        rst = 1'b1;
        pend.delete();
        #1;
        chk("mid_rst_req", {63'h0, imem_req_valid}, 64'd0);
        chk("mid_rst_instr", {63'h0, instr_valid}, 64'd0);
        step(1);
        chk("post_rst_req", {63'h0, imem_req_valid}, 64'd0);
        chk("post_rst_instr", {63'h0, instr_valid}, 64'd0);
        rst       = 1'b0;
        exp_pc    = RPC;
        fixed_lat = 1;
        rdy_mode  = 1;
        #1;
        chk("restart_addr", imem_req_addr, RPC);
        n0 = ncons;
        step(10);
        chk("restart_stream", 64'(ncons - n0), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
